// File: rtl/sign_mag_to_float_pkg.sv
// Shared definitions for the sign-magnitude to compact-float converter:
// default widths and the FSM state encoding.
package sign_mag_to_float_pkg;

  localparam int DEF_MAG_W  = 11;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_EXP_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sign_mag_to_float_if.sv
// Valid/ready bundle between the producer of sign-magnitude words, the
// converter, and the consumer of the (s, e, f) result.
interface sign_mag_to_float_if
  import sign_mag_to_float_pkg::*;
#(
  parameter int MAG_W  = DEF_MAG_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int EXP_W  = DEF_EXP_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [MAG_W:0]    sign_mag;
  logic              out_valid;
  logic              out_ready;
  logic              s;
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;

  modport master (
    output in_valid, sign_mag, out_ready,
    input  in_ready, out_valid, s, e, f
  );

  modport slave (
    input  in_valid, sign_mag, out_ready,
    output in_ready, out_valid, s, e, f
  );

endinterface

// File: rtl/sign_mag_to_float_fp_round.sv
// Combinational round-to-nearest of the normalised significand, with carry
// into the exponent and saturation at the largest representable value.
module fp_round #(
  parameter int FRAC_W = 4,
  parameter int EXP_W  = 3
) (
  input  logic [FRAC_W-1:0] f0,
  input  logic              rb,
  input  logic [EXP_W-1:0]  e0,
  output logic [FRAC_W-1:0] f,
  output logic [EXP_W-1:0]  e
);

  localparam logic [FRAC_W-1:0] F_MAX   = '1;
  localparam logic [EXP_W-1:0]  E_MAX   = '1;
  localparam logic [FRAC_W-1:0] F_CARRY = {1'b1, {(FRAC_W-1){1'b0}}};

  // Returns {e, f}; a significand overflow renormalises to 1000b with e+1.
  function automatic logic [EXP_W+FRAC_W-1:0] round_sat(
    input logic [FRAC_W-1:0] fi,
    input logic              rbi,
    input logic [EXP_W-1:0]  ei
  );
    if (!rbi)
      return {ei, fi};
    else if (fi != F_MAX)
      return {ei, fi + 1'b1};
    else if (ei != E_MAX)
      return {ei + 1'b1, F_CARRY};
    else
      return {E_MAX, F_MAX};
  endfunction

  always_comb begin
    {e, f} = round_sat(f0, rb, e0);
  end

endmodule

// File: rtl/sign_mag_to_float.sv
// Converts a sign-magnitude word into (s, e, f) with value (-1)^s * f * 2^e,
// normalising one bit per clock and handshaking on both sides.
module sign_mag_to_float
  import sign_mag_to_float_pkg::*;
#(
  parameter int MAG_W  = DEF_MAG_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic                clk,
  input  logic                rst,
  sign_mag_to_float_if.slave  bus
);

  localparam logic [EXP_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [MAG_W-1:0]  mag_r;
  logic [EXP_W-1:0]  cnt;
  logic              sign_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              s_r;
  logic [EXP_W-1:0]  e_r;
  logic [FRAC_W-1:0] f_r;
  logic [FRAC_W-1:0] f_rnd;
  logic [EXP_W-1:0]  e_rnd;

  // Exponent is the number of shifts not taken, i.e. CNT_MAX - cnt == ~cnt.
  fp_round #(
    .FRAC_W (FRAC_W),
    .EXP_W  (EXP_W)
  ) u_round (
    .f0 (mag_r[MAG_W-1 -: FRAC_W]),
    .rb (mag_r[MAG_W-1-FRAC_W]),
    .e0 (~cnt),
    .f  (f_rnd),
    .e  (e_rnd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mag_r       <= '0;
      cnt         <= '0;
      sign_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      s_r         <= 1'b0;
      e_r         <= '0;
      f_r         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r     <= bus.sign_mag[MAG_W];
            mag_r      <= bus.sign_mag[MAG_W-1:0];
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= NORM;
          end
        end
        NORM: begin
          // Shift count caps at CNT_MAX, leaving small values denormal at e=0.
          if (mag_r[MAG_W-1] || cnt == CNT_MAX) begin
            state <= ROUND;
          end else begin
            mag_r <= {mag_r[MAG_W-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
          end
        end
        ROUND: begin
          s_r         <= sign_r;
          e_r         <= e_rnd;
          f_r         <= f_rnd;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.e         = e_r;
  assign bus.f         = f_r;

endmodule

// File: tb/tb_sign_mag_to_float.sv
// Directed scoreboard bench for sign_mag_to_float: conversions, latency,
// back-pressure, and asynchronous reset abort.
module tb_sign_mag_to_float;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  sign_mag_to_float_if bus ();

  sign_mag_to_float dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word, pushes its expected result, waits for out_valid and
  // compares. hold>0 applies back-pressure for that many cycles; junk keeps
  // in_valid high with a different word while the converter is busy.
  task automatic run_word(input string tag, input logic [11:0] w,
                          input logic es, input logic [2:0] ee,
                          input logic [3:0] ef, input int elat,
                          input int hold, input bit junk);
    exp_t x;
    int   n;
    bit   got;
    @(negedge clk);
    bus.sign_mag  = w;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{s: es, e: ee, f: ef, lat: elat});
    @(negedge clk);
    if (junk) bus.sign_mag = ~w;
    else bus.in_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_valid_seen"}, 32'(got), 32'd1);
    if (got && sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, "_s"}, 32'(bus.s), 32'(x.s));
      chk({tag, "_e"}, 32'(bus.e), 32'(x.e));
      chk({tag, "_f"}, 32'(bus.f), 32'(x.f));
      chk({tag, "_lat"}, 32'(n), 32'(x.lat));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_hold_sef"}, 32'({bus.s, bus.e, bus.f}), 32'({x.s, x.e, x.f}));
        chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_release_in_ready"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sign_mag  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sef", 32'({bus.s, bus.e, bus.f}), 32'd0);
    rst = 1'b0;

    run_word("sat_2047",   12'h7FF,          1'b0, 3'd7, 4'd15, 2, 0, 1'b0);
    run_word("neg_470",    12'b1_00111010110, 1'b1, 3'd5, 4'd15, 4, 0, 1'b0);
    run_word("pos_1578",   12'b0_11000101010, 1'b0, 3'd7, 4'd12, 2, 0, 1'b1);
    run_word("carry_124",  12'h07C,          1'b0, 3'd4, 4'd8,  6, 0, 1'b0);
    run_word("neg_carry",  12'h8FF,          1'b1, 3'd5, 4'd8,  5, 0, 1'b0);
    run_word("exact_64",   12'h040,          1'b0, 3'd3, 4'd8,  6, 0, 1'b0);
    run_word("denorm_5",   12'h005,          1'b0, 3'd0, 4'd5,  9, 0, 1'b0);
    run_word("zero",       12'h000,          1'b0, 3'd0, 4'd0,  9, 0, 1'b0);
    run_word("neg_zero",   12'h800,          1'b1, 3'd0, 4'd0,  9, 0, 1'b0);
    run_word("hold_1024",  12'hC00,          1'b1, 3'd7, 4'd8,  2, 5, 1'b0);
    run_word("after_hold", 12'h07C,          1'b0, 3'd4, 4'd8,  6, 0, 1'b0);

    // Abort a word mid-normalisation with the asynchronous reset.
    @(negedge clk);
    bus.sign_mag = 12'h005;
    bus.in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{s: 1'b0, e: 3'd0, f: 4'd5, lat: 9});
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_sef", 32'({bus.s, bus.e, bus.f}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_word("post_abort", 12'b1_00111010110, 1'b1, 3'd5, 4'd15, 4, 0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
